// File: rtl/mdu_sequencer.sv
// Iterative unsigned multiply/divide unit for the EX stage.
// Shift-add multiply, restoring divide, 32 iterations per operation.
module mdu_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t      state;
  state_t      nstate;
  logic [1:0]  rop;
  logic [31:0] ra;
  logic [31:0] rb;
  logic [63:0] acc;
  logic [63:0] acc_n;
  logic [4:0]  cnt;
  logic        accept;
  logic        dz;
  logic        last;
  logic [32:0] sum;
  logic [32:0] shl;
  logic [32:0] diff;
  logic [31:0] rsel;

  assign accept = (state == IDLE) & start & ~flush;
  assign dz     = op[1] & (b == 32'd0);
  assign last   = (state == BUSY) & (cnt == 5'd31);
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);
  assign stall  = (state == BUSY) | accept;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    if (flush) begin
      nstate = IDLE;
    end else begin
      unique case (state)
        IDLE: if (start) nstate = dz ? DONE : BUSY;
        BUSY: if (cnt == 5'd31) nstate = DONE;
        DONE: nstate = IDLE;
        default: nstate = IDLE;
      endcase
    end
  end

  // dividend bits enter MSB first; ~cnt == 31-cnt
  always_comb begin
    sum  = {1'b0, acc[63:32]} + (rb[cnt] ? {1'b0, ra} : 33'd0);
    shl  = {acc[63:32], ra[~cnt]};
    diff = shl - {1'b0, rb};
    if (rop[1]) begin
      if (diff[32]) acc_n = {shl[31:0], acc[30:0], 1'b0};
      else          acc_n = {diff[31:0], acc[30:0], 1'b1};
    end else begin
      acc_n = {sum, acc[31:1]};
    end
    unique case (rop)
      2'b00:   rsel = acc_n[31:0];
      2'b01:   rsel = acc_n[63:32];
      2'b10:   rsel = acc_n[31:0];
      default: rsel = acc_n[63:32];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rop    <= 2'b00;
      ra     <= 32'd0;
      rb     <= 32'd0;
      acc    <= 64'd0;
      cnt    <= 5'd0;
      result <= 32'd0;
    end else if (accept) begin
      rop <= op;
      ra  <= a;
      rb  <= b;
      acc <= 64'd0;
      cnt <= 5'd0;
      if (dz) result <= op[0] ? a : 32'hFFFF_FFFF;
    end else if ((state == BUSY) && !flush) begin
      acc <= acc_n;
      cnt <= cnt + 5'd1;
      if (last) result <= rsel;
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer.
// Arithmetic reference model plus directed and random operations.
module tb_mdu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int npass = 0;
  int ntotal = 0;
  bit chk_en = 1'b0;

  mdu_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .stall(stall), .busy(busy), .done(done),
    .result(result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_op(input logic [1:0] o,
                                         input logic [31:0] x,
                                         input logic [31:0] y);
    logic [63:0] p;
    p = 64'(x) * 64'(y);
    case (o)
      2'b00:   return p[31:0];
      2'b01:   return p[63:32];
      2'b10:   return (y == 0) ? 32'hFFFF_FFFF : x / y;
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    ntotal++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %h expected %h @%0t", name, got, exp, $time);
  endtask

  // reference model: busy-cycles remaining, done flag, result
  int          m_left = 0;
  bit          m_done = 1'b0;
  logic [31:0] m_res = '0;
  logic [31:0] m_pend = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_left <= 0; m_done <= 1'b0; m_res <= '0;
    end else if (flush) begin
      m_left <= 0; m_done <= 1'b0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_left > 1) begin
      m_left <= m_left - 1;
    end else if (m_left == 1) begin
      m_left <= 0; m_done <= 1'b1; m_res <= m_pend;
    end else if (start) begin
      m_pend <= ref_op(op, a, b);
      if (op[1] && b == 0) begin
        m_done <= 1'b1; m_res <= ref_op(op, a, b);
      end else begin
        m_left <= 32;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(busy), 32'(m_left > 0 || m_done));
      check("done", 32'(done), 32'(m_done));
      check("stall", 32'(stall),
            32'(m_left > 0 || (!m_done && start && !flush)));
      check("result", result, m_res);
    end
  end

  task automatic run_op(input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input bit noisy,
                        output int lat);
    op = o; a = x; b = y; start = 1'b1;
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      start = noisy ? 1'($urandom) : 1'b0;
      op = 2'($urandom); a = $urandom; b = $urandom;
      if (done) begin
        lat = i;
        break;
      end
    end
    start = 1'b0;
    if (lat < 0) begin
      ntotal++;
      $display("FAIL timeout: no done for op %0d", o);
    end
    @(posedge clk); #1;
  endtask

  int lat;
  bit saw;

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_result", result, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);

    run_op(2'b00, 32'd7, 32'd6, 1'b0, lat);
    check("mul_7x6", result, 32'd42);
    check("model_mul", m_res, 32'd42);
    check("mul_lat", 32'(lat), 32'd33);

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat);
    check("mulhu_ff", result, 32'hFFFF_FFFE);
    check("model_mulhu", m_res, 32'hFFFF_FFFE);
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat);
    check("mul_ff", result, 32'd1);

    run_op(2'b10, 32'd100, 32'd7, 1'b0, lat);
    check("divu_100_7", result, 32'd14);
    check("divu_lat", 32'(lat), 32'd33);
    run_op(2'b11, 32'd100, 32'd7, 1'b0, lat);
    check("remu_100_7", result, 32'd2);
    check("model_remu", m_res, 32'd2);
    check("remu_lat", 32'(lat), 32'd33);

    run_op(2'b10, 32'd5, 32'd0, 1'b0, lat);
    check("divu_dz", result, 32'hFFFF_FFFF);
    check("divu_dz_lat", 32'(lat), 32'd1);
    run_op(2'b11, 32'd5, 32'd0, 1'b0, lat);
    check("remu_dz", result, 32'd5);

    // flush in the middle of a multiply
    op = 2'b00; a = 32'd9; b = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_result", result, 32'd5);
    saw = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) saw = 1'b1;
    end
    check("flush_nodone", 32'(saw), 32'd0);
    run_op(2'b00, 32'd3, 32'd3, 1'b0, lat);
    check("mul_3x3", result, 32'd9);

    // reset in the middle of a divide
    op = 2'b10; a = 32'd77; b = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstmid_result", result, 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_stall", 32'(stall), 32'd0);
    saw = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) saw = 1'b1;
    end
    check("rstmid_nodone", 32'(saw), 32'd0);

    // start pulses and operand churn while busy
    run_op(2'b10, 32'd1000, 32'd3, 1'b1, lat);
    check("noisy_divu", result, 32'd333);
    check("noisy_lat", 32'(lat), 32'd33);

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra;
      logic [31:0] rb;
      ro = 2'($urandom);
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 :
           ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) :
           $urandom;
      run_op(ro, ra, rb, 1'($urandom), lat);
      check("rand_result", result, ref_op(ro, ra, rb));
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
